// File: rtl/checkpoint_ctrl.sv
// ---------------------------------------------------------------------------
// checkpoint_ctrl
//
// Allocates and frees branch checkpoint slots for the rename stage. Slots are
// managed as a circular queue: saves allocate at the tail, retiring branches
// free at the head, and a mispredict rolls the tail back to the restored slot.
// A rollback keeps the block busy for one cycle while the map table is
// rewritten.
//
// Ports
//   clk            single clock, rising edge
//   rst            asynchronous reset, active-high
//   save_valid     rename requests a new checkpoint
//   save_ready     a slot can be allocated this cycle
//   save_index     slot handed out when save_valid && save_ready
//   commit_valid   oldest checkpointed branch retired
//   commit_index   slot being freed (must be the head slot)
//   restore_valid  mispredict, roll back to restore_index
//   restore_index  slot to restore from; it and all younger slots are freed
//   restore_busy   map table rewrite in progress
//   occupancy      number of allocated slots, 0..CHECKPOINT_COUNT
//   throttle       free slots at or below CHECKPOINT_THRESHOLD
//   error          sticky protocol-violation flag
// ---------------------------------------------------------------------------
module checkpoint_ctrl #(
    parameter int CHECKPOINT_COUNT       = 8,
    parameter int CHECKPOINT_INDEX_WIDTH = 3,
    parameter int CHECKPOINT_THRESHOLD   = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              save_valid,
    output logic                              save_ready,
    output logic [CHECKPOINT_INDEX_WIDTH-1:0] save_index,
    input  logic                              commit_valid,
    input  logic [CHECKPOINT_INDEX_WIDTH-1:0] commit_index,
    input  logic                              restore_valid,
    input  logic [CHECKPOINT_INDEX_WIDTH-1:0] restore_index,
    output logic                              restore_busy,
    output logic [CHECKPOINT_INDEX_WIDTH:0]   occupancy,
    output logic                              throttle,
    output logic                              error
);

    localparam int IDX_WIDTH = CHECKPOINT_INDEX_WIDTH;
    localparam int PTR_WIDTH = CHECKPOINT_INDEX_WIDTH + 1;
    localparam logic [PTR_WIDTH-1:0] FULL_COUNT = PTR_WIDTH'(CHECKPOINT_COUNT);

    typedef enum logic {
        IDLE,
        RESTORE
    } state_t;

    state_t                 state;
    state_t                 state_next;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_WIDTH-1:0]   head;
    logic [PTR_WIDTH-1:0]   tail;
    logic [PTR_WIDTH-1:0]   head_next;
    logic [PTR_WIDTH-1:0]   tail_next;
    logic [PTR_WIDTH-1:0]   occ;
    logic [PTR_WIDTH-1:0]   occ_post;
    logic [PTR_WIDTH-1:0]   free_slots;
    logic [PTR_WIDTH-1:0]   restore_ptr;
    logic [IDX_WIDTH-1:0]   restore_offset;
    logic                   full;
    logic                   empty;
    logic                   commit_ok;
    logic                   commit_err;
    logic                   restore_ok;
    logic                   restore_err;
    logic                   save_fire;
    logic                   error_next;

    assign occ        = tail - head;
    assign full       = (occ == FULL_COUNT);
    assign empty      = (occ == '0);
    assign free_slots = FULL_COUNT - occ;

    assign occupancy    = occ;
    assign save_index   = tail[IDX_WIDTH-1:0];
    assign save_ready   = !full && (state == IDLE) && !restore_valid;
    assign restore_busy = (state == RESTORE);
    assign throttle     = ($unsigned(32'(free_slots)) <= $unsigned(32'(CHECKPOINT_THRESHOLD)));

    // Commit is resolved first against the current head; the restore is then
    // range-checked against the head as it will be after that commit. A
    // restore aimed at the slot being committed therefore lands outside the
    // live range and is rejected while the commit still proceeds.
    always_comb begin
        state_next     = IDLE;
        head_next      = head;
        tail_next      = tail;
        commit_ok      = 1'b0;
        commit_err     = 1'b0;
        restore_ok     = 1'b0;
        restore_err    = 1'b0;
        save_fire      = save_valid && save_ready;
        restore_offset = '0;
        restore_ptr    = tail;
        occ_post       = occ;

        if (commit_valid) begin
            if (!empty && (commit_index == head[IDX_WIDTH-1:0])) begin
                commit_ok = 1'b1;
                head_next = head + 1'b1;
            end else begin
                commit_err = 1'b1;
            end
        end

        occ_post = tail - head_next;

        // The offset from the head wraps modulo the slot count, so the
        // restored pointer is head plus that offset, which keeps it in
        // [head, tail) whenever the offset is below the live count.
        if (restore_valid) begin
            restore_offset = restore_index - head_next[IDX_WIDTH-1:0];
            restore_ptr    = head_next + PTR_WIDTH'(restore_offset);
            if (PTR_WIDTH'(restore_offset) < occ_post) begin
                restore_ok = 1'b1;
                tail_next  = restore_ptr;
                state_next = RESTORE;
            end else begin
                restore_err = 1'b1;
            end
        end else if (save_fire) begin
            tail_next = tail + 1'b1;
        end

        error_next = error || commit_err || restore_err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            head  <= '0;
            tail  <= '0;
            error <= 1'b0;
        end else begin
            state <= state_next;
            head  <= head_next;
            tail  <= tail_next;
            error <= error_next;
        end
    end

endmodule

// File: tb/tb_checkpoint_ctrl.sv
// ---------------------------------------------------------------------------
// tb_checkpoint_ctrl
//
// Scoreboard bench for checkpoint_ctrl. The stimulus process drives inputs
// just after each rising edge, predicts every output for that cycle from a
// slot-list reference model and queues the prediction. A monitor samples the
// DUT on each falling edge and compares against the oldest prediction.
// ---------------------------------------------------------------------------
module tb_checkpoint_ctrl;

    localparam int N = 8;

    logic       clk;
    logic       rst;
    logic       save_valid;
    logic       save_ready;
    logic [2:0] save_index;
    logic       commit_valid;
    logic [2:0] commit_index;
    logic       restore_valid;
    logic [2:0] restore_index;
    logic       restore_busy;
    logic [3:0] occupancy;
    logic       throttle;
    logic       error;

    checkpoint_ctrl #(
        .CHECKPOINT_COUNT       (8),
        .CHECKPOINT_INDEX_WIDTH (3),
        .CHECKPOINT_THRESHOLD   (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .save_valid    (save_valid),
        .save_ready    (save_ready),
        .save_index    (save_index),
        .commit_valid  (commit_valid),
        .commit_index  (commit_index),
        .restore_valid (restore_valid),
        .restore_index (restore_index),
        .restore_busy  (restore_busy),
        .occupancy     (occupancy),
        .throttle      (throttle),
        .error         (error)
    );

    typedef struct {
        int step;
        int saveReady;
        int saveIndex;
        int occupancy;
        int throttle;
        int busy;
        int error;
    } expect_t;

    expect_t sbQueue[$];

    // Reference model: the live slots in allocation order, the next slot to
    // hand out, the busy flag and the sticky error flag.
    int slots[$];
    int nextIdx;
    int busy;
    int errFlag;

    int checks;
    int errors;
    int stepNo;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input int step, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s step %0d: got %0d expected %0d", name, step, actual, expected);
        end
    endtask

    // Monitor: compares the DUT against the oldest queued prediction.
    initial begin
        expect_t e;
        forever begin
            @(negedge clk);
            if (sbQueue.size() > 0) begin
                e = sbQueue.pop_front();
                checkOutput("save_ready",   e.step, int'(save_ready),   e.saveReady);
                checkOutput("save_index",   e.step, int'(save_index),   e.saveIndex);
                checkOutput("occupancy",    e.step, int'(occupancy),    e.occupancy);
                checkOutput("throttle",     e.step, int'(throttle),     e.throttle);
                checkOutput("restore_busy", e.step, int'(restore_busy), e.busy);
                checkOutput("error",        e.step, int'(error),        e.error);
            end
        end
    end

    function automatic expect_t predict(input int rv);
        expect_t e;
        e.step      = stepNo;
        e.saveReady = (slots.size() < N && busy == 0 && rv == 0) ? 1 : 0;
        e.saveIndex = nextIdx;
        e.occupancy = slots.size();
        e.throttle  = ((N - slots.size()) <= 3) ? 1 : 0;
        e.busy      = busy;
        e.error     = errFlag;
        return e;
    endfunction

    task automatic applyReset();
        @(posedge clk);
        #1;
        rst           = 1'b1;
        save_valid    = 1'b0;
        commit_valid  = 1'b0;
        commit_index  = 3'd0;
        restore_valid = 1'b0;
        restore_index = 3'd0;
        slots.delete();
        nextIdx = 0;
        busy    = 0;
        errFlag = 0;
        stepNo++;
        sbQueue.push_back(predict(0));
    endtask

    task automatic applyStimulus(input int sv, input int cv, input int ci, input int rv, input int ri);
        expect_t e;
        int      pos;
        int      newBusy;
        @(posedge clk);
        #1;
        rst           = 1'b0;
        save_valid    = (sv != 0);
        commit_valid  = (cv != 0);
        commit_index  = 3'(ci);
        restore_valid = (rv != 0);
        restore_index = 3'(ri);
        stepNo++;
        e = predict(rv);
        sbQueue.push_back(e);

        if (cv != 0) begin
            if (slots.size() > 0 && slots[0] == ci) void'(slots.pop_front());
            else errFlag = 1;
        end
        newBusy = 0;
        if (rv != 0) begin
            pos = -1;
            foreach (slots[k]) if (slots[k] == ri && pos < 0) pos = k;
            if (pos >= 0) begin
                while (slots.size() > pos) void'(slots.pop_back());
                nextIdx = ri;
                newBusy = 1;
            end else begin
                errFlag = 1;
            end
        end
        if (sv != 0 && e.saveReady != 0) begin
            slots.push_back(nextIdx);
            nextIdx = (nextIdx + 1) % N;
        end
        busy = newBusy;
    endtask

    initial begin
        int sv, cv, ci, rv, ri;
        checks = 0;
        errors = 0;
        stepNo = 0;
        rst           = 1'b1;
        save_valid    = 1'b0;
        commit_valid  = 1'b0;
        commit_index  = 3'd0;
        restore_valid = 1'b0;
        restore_index = 3'd0;

        // Fill from reset, then one more save attempt against a full queue.
        applyReset();
        for (int i = 0; i < 9; i++) applyStimulus(1, 0, 0, 0, 0);
        // Wrap: free four from the head, refill, then commit the new head.
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, i, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 1, 4, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);

        // Restore to slot 2 of six, save while busy, then save again.
        applyReset();
        for (int i = 0; i < 6; i++) applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 2);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);

        // Commit and restore together: valid target, then the committed slot.
        applyReset();
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 1, 2);
        applyStimulus(0, 0, 0, 0, 0);
        applyReset();
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0);

        // Protocol errors: empty commit, wrong commit index, out-of-range restore.
        applyReset();
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyReset();
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 1, 5, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyReset();
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 5);
        applyStimulus(1, 0, 0, 0, 0);

        // Reset asserted while a restore is in progress.
        applyReset();
        for (int i = 0; i < 6; i++) applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 2);
        applyReset();
        applyStimulus(0, 0, 0, 0, 0);

        // Randomised traffic with occasional resets.
        applyReset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                applyReset();
            end else begin
                sv = ($urandom_range(0, 99) < 60) ? 1 : 0;
                cv = ($urandom_range(0, 99) < 35) ? 1 : 0;
                if (slots.size() > 0 && $urandom_range(0, 99) < 95) ci = slots[0];
                else ci = int'($urandom_range(0, 7));
                rv = ($urandom_range(0, 99) < 8) ? 1 : 0;
                if (slots.size() > 0 && $urandom_range(0, 99) < 85)
                    ri = slots[$urandom_range(0, slots.size() - 1)];
                else
                    ri = int'($urandom_range(0, 7));
                applyStimulus(sv, cv, ci, rv, ri);
            end
        end

        for (int i = 0; i < 10 && sbQueue.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        if (sbQueue.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: got %0d pending expected 0", sbQueue.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
